ram_be_sdp: RTL and testbench

Simple dual-port synchronous RAM with per-byte write enables, registered read, hardware zero-initialisation after reset, and optional same-address write-to-read forwarding. This is the next generation of the team's single-port byte-enable RAM, generalised to arbitrary data and byte widths. It sits between producers and consumers that need one write and one read per cycle, such as stack and buffer storage.

---
 rtl/ram_be_sdp.sv | 131 +++++++++++++
 tb/tb_ram_be_sdp.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_be_sdp.sv
`default_nettype none
// ============================================================================
// Module   : ram_be_sdp
// Function : Simple dual-port RAM with per-byte write enables, registered read
//            and a zero-fill sweep after reset. Define RAM_BYPASS_EN to forward
//            same-address write data to the read port.
// Revision : 1.0
// ============================================================================
module ram_be_sdp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             init_busy
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    // One spare counter bit keeps the terminal count free of wrap-around.
    localparam logic [ADDR_WIDTH:0] c_LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH:0]     r_cnt;
    logic [ADDR_WIDTH:0]     w_cnt_next;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_rd_valid;

    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_data;
    logic [NUM_BYTES-1:0]    w_mem_be;
    logic                    w_rd_fire;
    logic [DATA_WIDTH-1:0]   w_rd_old;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mem_we     = 1'b0;
        w_mem_addr   = wr_addr;
        w_mem_data   = wr_data;
        w_mem_be     = wr_be;
        w_rd_fire    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt[ADDR_WIDTH-1:0];
                w_mem_data = '0;
                w_mem_be   = '1;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_mem_we  = wr_en;
                w_rd_fire = rd_en;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    // Storage carries no reset; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign w_rd_old = r_mem[rd_addr];

`ifdef RAM_BYPASS_EN
    logic w_hit;
    assign w_hit = wr_en && (wr_addr == rd_addr);

    generate
        for (genvar g = 0; g < NUM_BYTES; g++) begin : g_bypass
            assign w_rd_word[g*BYTE_WIDTH +: BYTE_WIDTH] = (w_hit && wr_be[g]) ?
                wr_data[g*BYTE_WIDTH +: BYTE_WIDTH] : w_rd_old[g*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate
`else
    assign w_rd_word = w_rd_old;
`endif

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign init_busy = (r_state == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_ram_be_sdp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_be_sdp
// Function : Self-checking bench for ram_be_sdp (default and 32-bit builds).
// Revision : 1.0
// ============================================================================
module tb_ram_be_sdp;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int NB    = 2;
    localparam int DEPTH = 256;
    localparam int DW32  = 32;
    localparam int AW32  = 4;
    localparam int NB32  = 4;

`ifdef RAM_BYPASS_EN
    localparam bit          BYPASS = 1'b1;
    localparam logic [15:0] c_COLL = 16'h55AA;
`else
    localparam bit          BYPASS = 1'b0;
    localparam logic [15:0] c_COLL = 16'hAAAA;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [NB-1:0]   wr_be = '0;
    logic            rd_en = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            init_busy;

    logic            wr_en32 = 1'b0;
    logic [AW32-1:0] wr_addr32 = '0;
    logic [DW32-1:0] wr_data32 = '0;
    logic [NB32-1:0] wr_be32 = '0;
    logic            rd_en32 = 1'b0;
    logic [AW32-1:0] rd_addr32 = '0;
    logic [DW32-1:0] rd_data32;
    logic            rd_valid32;
    logic            init_busy32;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rd;
    logic          exp_valid;

    always #5 clk = ~clk;

    ram_be_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .init_busy(init_busy)
    );

    ram_be_sdp #(.DATA_WIDTH(DW32), .ADDR_WIDTH(AW32), .BYTE_WIDTH(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en32), .wr_addr(wr_addr32), .wr_data(wr_data32),
        .wr_be(wr_be32), .rd_en(rd_en32), .rd_addr(rd_addr32), .rd_data(rd_data32),
        .rd_valid(rd_valid32), .init_busy(init_busy32)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) mask[i*8 +: 8] = 8'hFF;
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_rd    = '0;
        exp_valid = 1'b0;
    endtask

    // One RUN-mode cycle; the model predicts what the read port shows afterwards.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        @(posedge clk); #1;
        if (re) begin
            if (BYPASS && we && (wa == ra)) exp_rd = merge(ref_mem[ra], wd, be);
            else                            exp_rd = ref_mem[ra];
        end
        exp_valid = re;
        if (we) ref_mem[wa] = merge(ref_mem[wa], wd, be);
        idle();
    endtask

    // Random requests during the sweep; counts edges until init_busy drops.
    task automatic count_busy(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (n < 1000) begin
            wr_en = 1'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
            wr_be = NB'($urandom); rd_en = 1'($urandom); rd_addr = AW'($urandom);
            @(posedge clk); #1;
            n++;
            if (rd_valid) saw_valid = 1'b1;
            if (!init_busy) break;
        end
        idle();
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, '0, '0, '0, 1'b1, AW'(a));
            checks++;
            if (rd_data !== 16'h0000 || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s addr %0h: got %h/%b required 0000/1", tag, a, rd_data, rd_valid);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        bit sv;
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got data=%h valid=%b busy=%b required 0/0/1", rd_data, rd_valid, init_busy);
        end
        rst_n = 1'b1;
        count_busy(n, sv);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL init_length: got %0d edges required 256", n);
        end
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL init_rd_valid: got pulse during sweep required none");
        end
        reset_model();
        read_all_zero("init_zero");
    endtask

    task automatic test_full_write();
        step(1'b1, 8'h10, 16'hBEEF, 2'b11, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 8'h10);
        checks++;
        if (rd_data !== 16'hBEEF || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_write: got %h/%b required beef/1", rd_data, rd_valid);
        end
        step(1'b0, '0, '0, '0, 1'b0, '0);
        checks++;
        if (rd_data !== 16'hBEEF || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: got %h/%b required beef/0", rd_data, rd_valid);
        end
    endtask

    task automatic test_byte_enable();
        step(1'b1, 8'h20, 16'hBEEF, 2'b11, 1'b0, '0);
        step(1'b1, 8'h20, 16'h1234, 2'b01, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 8'h20);
        checks++;
        if (rd_data !== 16'hBE34) begin
            errors++;
            $display("FAIL lane_write: got %h required be34", rd_data);
        end
        step(1'b1, 8'h20, 16'hFFFF, 2'b00, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 8'h20);
        checks++;
        if (rd_data !== 16'hBE34) begin
            errors++;
            $display("FAIL no_lane_write: got %h required be34", rd_data);
        end
    endtask

    task automatic test_collision();
        step(1'b1, 8'h05, 16'hAAAA, 2'b11, 1'b0, '0);
        step(1'b1, 8'h05, 16'h5555, 2'b10, 1'b1, 8'h05);
        checks++;
        if (rd_data !== c_COLL || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL same_addr: got %h/%b required %h/1", rd_data, rd_valid, c_COLL);
        end
        step(1'b0, '0, '0, '0, 1'b1, 8'h05);
        checks++;
        if (rd_data !== 16'h55AA) begin
            errors++;
            $display("FAIL after_same_addr: got %h required 55aa", rd_data);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            step(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), NB'($urandom),
                 1'($urandom), AW'($urandom_range(0, 15)));
            checks++;
            if (rd_data !== exp_rd || rd_valid !== exp_valid) begin
                errors++;
                $display("FAIL random cycle %0d: got %h/%b required %h/%b", k, rd_data, rd_valid, exp_rd, exp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 32; a++) begin
            step(1'b1, AW'(8'h40 + a), DW'($urandom), 2'b11, a > 0, AW'(8'h40 + a - 1));
        end
        for (int a = 0; a < 32; a++) begin
            step(1'b0, '0, '0, '0, 1'b1, AW'(8'h40 + a));
            checks++;
            if (rd_data !== exp_rd || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back addr %0h: got %h/%b required %h/1", 8'h40 + a, rd_data, rd_valid, exp_rd);
            end
        end
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        bit sv;
        bit early;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_data !== '0 || rd_valid !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL run_reset: got data=%h valid=%b busy=%b required 0/0/1", rd_data, rd_valid, init_busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        early = 1'b0;
        sv = 1'b0;
        for (int k = 0; k < 100; k++) begin
            wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = DW'($urandom); wr_be = '1;
            rd_en = 1'b1; rd_addr = AW'($urandom);
            @(posedge clk); #1;
            if (!init_busy) early = 1'b1;
            if (rd_valid) sv = 1'b1;
        end
        idle();
        checks++;
        if (early !== 1'b0 || sv !== 1'b0) begin
            errors++;
            $display("FAIL sweep_ignore: got early_done=%b valid_seen=%b required 0/0", early, sv);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (init_busy !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b valid=%b required 1/0", init_busy, rd_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(n, sv);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL restart_length: got %0d edges required 256", n);
        end
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL restart_rd_valid: got pulse during sweep required none");
        end
        reset_model();
        read_all_zero("restart_zero");
    endtask

    task automatic test_wide();
        checks++;
        if (init_busy32 !== 1'b0) begin
            errors++;
            $display("FAIL wide_init: got busy=%b required 0", init_busy32);
        end
        wr_en32 = 1'b1; wr_addr32 = 4'h3; wr_data32 = 32'hDEADBEEF; wr_be32 = 4'b0101;
        @(posedge clk); #1;
        wr_en32 = 1'b0; rd_en32 = 1'b1; rd_addr32 = 4'h3;
        @(posedge clk); #1;
        rd_en32 = 1'b0;
        checks++;
        if (rd_data32 !== 32'h00AD00EF || rd_valid32 !== 1'b1) begin
            errors++;
            $display("FAIL wide_lanes: got %h/%b required 00ad00ef/1", rd_data32, rd_valid32);
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_byte_enable();
        test_collision();
        test_random();
        test_back_to_back();
        test_mid_sweep_reset();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
